// File: rtl/status_tx.sv
// Status responder: turns a host command byte into a short response byte
// stream for a UART transmitter, with back-to-back chaining and overrun flag.
module status_tx #(
    parameter logic [7:0] TERM     = 8'h0A,
    parameter logic [7:0] ERR_CHAR = 8'h3F
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Cmd,
    input  logic       CmdValid,
    input  logic       ADCPower,
    input  logic       AnalogPower,
    output logic [7:0] TxData,
    output logic       TxValid,
    input  logic       TxReady,
    output logic       Busy,
    output logic       Overrun
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t      state_r, state_n;
    logic [1:0]  idx_r, idx_n;
    logic [2:0]  len_r, len_n;
    logic [7:0]  cmd_r, cmd_n;
    logic        adc_r, adc_n;
    logic        ana_r, ana_n;
    logic [7:0]  tx_data_r, tx_data_n;
    logic        tx_valid_r, tx_valid_n;
    logic        busy_r;
    logic        overrun_r, overrun_n;

    logic        xfer_s;
    logic        last_s;
    logic        final_xfer_s;
    logic        accept_s;
    logic        drop_s;

    function automatic logic [2:0] len_of(input logic [7:0] c);
        case (c)
            8'h53:   len_of = 3'd4;
            default: len_of = 3'd2;
        endcase
    endfunction

    function automatic logic [7:0] byte_at(input logic [7:0] c, input logic adc,
                                           input logic ana, input logic [1:0] i);
        case (c)
            8'h4F, 8'h6F, 8'h50, 8'h70: byte_at = (i == 2'd0) ? c : TERM;
            8'h53: begin
                case (i)
                    2'd0:    byte_at = 8'h53;
                    2'd1:    byte_at = adc ? 8'h31 : 8'h30;
                    2'd2:    byte_at = ana ? 8'h31 : 8'h30;
                    default: byte_at = TERM;
                endcase
            end
            default: byte_at = (i == 2'd0) ? ERR_CHAR : TERM;
        endcase
    endfunction

    // TxValid is high exactly while in SEND, so a handshake implies SEND.
    assign xfer_s       = tx_valid_r & TxReady;
    assign last_s       = ({1'b0, idx_r} == (len_r - 3'd1));
    assign final_xfer_s = (state_r == SEND) & xfer_s & last_s;
    assign accept_s     = CmdValid & ((state_r == IDLE) | final_xfer_s);
    assign drop_s       = CmdValid & (state_r == SEND) & ~final_xfer_s;

    // Next-state, byte index and output byte selection.
    always_comb begin
        state_n    = state_r;
        idx_n      = idx_r;
        len_n      = len_r;
        cmd_n      = cmd_r;
        adc_n      = adc_r;
        ana_n      = ana_r;
        tx_valid_n = tx_valid_r;
        tx_data_n  = tx_data_r;
        overrun_n  = overrun_r | drop_s;
        if (accept_s) begin
            state_n    = SEND;
            idx_n      = 2'd0;
            len_n      = len_of(Cmd);
            cmd_n      = Cmd;
            adc_n      = ADCPower;
            ana_n      = AnalogPower;
            tx_valid_n = 1'b1;
            tx_data_n  = byte_at(Cmd, ADCPower, AnalogPower, 2'd0);
        end else if (final_xfer_s) begin
            state_n    = IDLE;
            idx_n      = 2'd0;
            tx_valid_n = 1'b0;
        end else if ((state_r == SEND) && xfer_s) begin
            idx_n      = idx_r + 2'd1;
            tx_data_n  = byte_at(cmd_r, adc_r, ana_r, idx_r + 2'd1);
        end else begin
            idx_n      = idx_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r    <= IDLE;
            idx_r      <= 2'd0;
            len_r      <= 3'd2;
            cmd_r      <= 8'h00;
            adc_r      <= 1'b0;
            ana_r      <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_n;
            idx_r      <= idx_n;
            len_r      <= len_n;
            cmd_r      <= cmd_n;
            adc_r      <= adc_n;
            ana_r      <= ana_n;
            tx_valid_r <= tx_valid_n;
            tx_data_r  <= tx_data_n;
            busy_r     <= (state_n == SEND);
            overrun_r  <= overrun_n;
        end
    end

    assign TxData  = tx_data_r;
    assign TxValid = tx_valid_r;
    assign Busy    = busy_r;
    assign Overrun = overrun_r;

endmodule

// File: tb/tb_status_tx.sv
// Bench for status_tx: directed vector table plus randomized traffic,
// both checked against a byte-queue reference model.
module tb_status_tx;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] Cmd;
    logic       CmdValid;
    logic       ADCPower;
    logic       AnalogPower;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;
    logic       Busy;
    logic       Overrun;

    status_tx dut (
        .Clock(Clock), .Reset(Reset), .Cmd(Cmd), .CmdValid(CmdValid),
        .ADCPower(ADCPower), .AnalogPower(AnalogPower), .TxData(TxData),
        .TxValid(TxValid), .TxReady(TxReady), .Busy(Busy), .Overrun(Overrun)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    logic       m_ovr = 1'b0;
    logic       m_reset = 1'b0;

    typedef struct {
        logic [7:0] cmd;
        logic       cv, adc, ana, rdy, rst;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_busy, e_ovr;
    } vec_t;
    vec_t tbl[$];

    function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push_resp(logic [7:0] c, logic adc, logic ana);
        if (c == "O" || c == "o" || c == "P" || c == "p") begin
            q.push_back(c); q.push_back(8'h0A);
        end else if (c == "S") begin
            q.push_back(8'h53);
            q.push_back(adc ? 8'h31 : 8'h30);
            q.push_back(ana ? 8'h31 : 8'h30);
            q.push_back(8'h0A);
        end else begin
            q.push_back(8'h3F); q.push_back(8'h0A);
        end
    endfunction

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic step(input logic [7:0] c, input logic cv, input logic adc,
                        input logic ana, input logic rdy, input logic rst);
        logic m_valid;
        logic fin;
        Cmd = c; CmdValid = cv; ADCPower = adc; AnalogPower = ana;
        TxReady = rdy; Reset = rst;
        @(posedge Clock);
        if (rst) begin
            q.delete();
            m_ovr = 1'b0;
            m_reset = 1'b1;
        end else begin
            m_valid = (q.size() > 0);
            fin = 1'b0;
            if (m_valid && rdy) begin
                void'(q.pop_front());
                fin = (q.size() == 0);
            end
            if (cv && (!m_valid || fin)) push_resp(c, adc, ana);
            else if (cv) m_ovr = 1'b1;
            m_reset = 1'b0;
        end
        #1;
        chk("model_valid", {7'd0, TxValid}, {7'd0, q.size() > 0});
        chk("model_busy", {7'd0, Busy}, {7'd0, q.size() > 0});
        chk("model_overrun", {7'd0, Overrun}, {7'd0, m_ovr});
        if (q.size() > 0) chk("model_data", TxData, q[0]);
        if (m_reset) chk("reset_data", TxData, 8'h00);
    endtask

    function automatic void add(logic [7:0] c, logic cv, logic adc, logic ana,
                                logic rdy, logic rst, logic ev, logic [7:0] ed,
                                logic eb, logic eo);
        vec_t v;
        v.cmd = c; v.cv = cv; v.adc = adc; v.ana = ana; v.rdy = rdy; v.rst = rst;
        v.e_valid = ev; v.e_data = ed; v.e_busy = eb; v.e_ovr = eo;
        tbl.push_back(v);
    endfunction

    initial begin
        // reset, with a command strobe that must be ignored
        add(8'h4F, 1, 0, 0, 1, 1,   0, 8'h00, 0, 0);
        add(8'h00, 0, 0, 0, 1, 1,   0, 8'h00, 0, 0);
        // "O" with TxReady held high
        add(8'h4F, 1, 0, 0, 1, 0,   1, 8'h4F, 1, 0);
        add(8'h00, 0, 0, 0, 1, 0,   1, 8'h0A, 1, 0);
        add(8'h00, 0, 0, 0, 1, 0,   0, 8'h00, 0, 0);
        // unknown command stalled for 5 cycles
        add(8'h41, 1, 0, 0, 0, 0,   1, 8'h3F, 1, 0);
        for (int i = 0; i < 5; i++) add(8'h00, 0, 0, 0, 0, 0, 1, 8'h3F, 1, 0);
        add(8'h00, 0, 0, 0, 1, 0,   1, 8'h0A, 1, 0);
        add(8'h00, 0, 0, 0, 1, 0,   0, 8'h00, 0, 0);
        // "P" dropped during byte 0, then "p" chained on final TERM
        add(8'h4F, 1, 0, 0, 1, 0,   1, 8'h4F, 1, 0);
        add(8'h50, 1, 0, 0, 1, 0,   1, 8'h0A, 1, 1);
        add(8'h70, 1, 0, 0, 1, 0,   1, 8'h70, 1, 1);
        add(8'h00, 0, 0, 0, 1, 0,   1, 8'h0A, 1, 1);
        add(8'h00, 0, 0, 0, 1, 0,   0, 8'h00, 0, 1);
        // "S" snapshot: power inputs change after acceptance
        add(8'h53, 1, 1, 0, 1, 0,   1, 8'h53, 1, 1);
        add(8'h00, 0, 0, 1, 1, 0,   1, 8'h31, 1, 1);
        add(8'h00, 0, 0, 1, 1, 0,   1, 8'h30, 1, 1);
        add(8'h00, 0, 0, 1, 1, 0,   1, 8'h0A, 1, 1);
        add(8'h00, 0, 0, 1, 1, 0,   0, 8'h00, 0, 1);
        // reset after two bytes of an "S" response
        add(8'h53, 1, 1, 1, 1, 0,   1, 8'h53, 1, 1);
        add(8'h00, 0, 1, 1, 1, 0,   1, 8'h31, 1, 1);
        add(8'h00, 0, 1, 1, 1, 0,   1, 8'h31, 1, 1);
        add(8'h00, 0, 1, 1, 1, 1,   0, 8'h00, 0, 0);
        add(8'h00, 0, 1, 1, 1, 0,   0, 8'h00, 0, 0);
        add(8'h00, 0, 1, 1, 1, 0,   0, 8'h00, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].cmd, tbl[i].cv, tbl[i].adc, tbl[i].ana, tbl[i].rdy, tbl[i].rst);
            chk($sformatf("vec%0d_valid", i), {7'd0, TxValid}, {7'd0, tbl[i].e_valid});
            chk($sformatf("vec%0d_busy", i), {7'd0, Busy}, {7'd0, tbl[i].e_busy});
            chk($sformatf("vec%0d_overrun", i), {7'd0, Overrun}, {7'd0, tbl[i].e_ovr});
            if (tbl[i].e_valid || tbl[i].rst)
                chk($sformatf("vec%0d_data", i), TxData, tbl[i].e_data);
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] c;
            case ($urandom_range(0, 5))
                0: c = "O";
                1: c = "o";
                2: c = "P";
                3: c = "p";
                4: c = "S";
                default: c = 8'($urandom);
            endcase
            step(c, ($urandom_range(0, 9) < 3), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
